// File: rtl/intpol2_pkg.sv
// rtl/intpol2_pkg.sv - shared constants and state encoding for the intpol2 output side
package intpol2_pkg;

  localparam int unsigned INTPOL2_ADDR_WIDTH = 20;
  localparam int unsigned INTPOL2_DATA_WIDTH = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_RUN   = RUN,
    ST_FLUSH = FLUSH,
    ST_DONE  = DONE
  } sink_state_e;

endpackage

// File: rtl/intpol2_sink_wr_stage.sv
// rtl/intpol2_sink_wr_stage.sv - two-stage read-to-write pipeline feeding the Y memories
module intpol2_sink_wr_stage
  import intpol2_pkg::*;
#(
  parameter int ADDR_WIDTH = INTPOL2_ADDR_WIDTH,
  parameter int DATA_WIDTH = INTPOL2_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  re_i,
  input  logic [DATA_WIDTH-1:0] data_I_i,
  input  logic [DATA_WIDTH-1:0] data_Q_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_I_o,
  output logic [DATA_WIDTH-1:0] data_Q_o,
  output logic [ADDR_WIDTH-1:0] wr_cnt_o,
  output logic [ADDR_WIDTH-1:0] wr_next_o,
  output logic                  pending_o
);

  // valid_q marks the cycle the FIFO read data is on the bus; we_q is the write cycle
  logic                  valid_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wr_cnt_q;
  logic [DATA_WIDTH-1:0] data_I_q;
  logic [DATA_WIDTH-1:0] data_Q_q;

  // Capture FIFO data when valid, advance the write address after every write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      wr_cnt_q <= '0;
      data_I_q <= '0;
      data_Q_q <= '0;
    end else begin
      valid_q <= re_i;
      we_q    <= valid_q;
      if (valid_q) begin
        data_I_q <= data_I_i;
        data_Q_q <= data_Q_i;
      end
      if (clear_i) begin
        wr_cnt_q <= '0;
      end else if (we_q) begin
        wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign we_o      = we_q;
  assign addr_o    = wr_cnt_q;
  assign data_I_o  = data_I_q;
  assign data_Q_o  = data_Q_q;
  assign wr_cnt_o  = wr_cnt_q;
  // Write count as it will be after the current cycle, so completion is seen one cycle earlier
  assign wr_next_o = wr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, we_q};
  assign pending_o = valid_q;

endmodule

// File: rtl/intpol2_sink_ctrl.sv
// rtl/intpol2_sink_ctrl.sv - drains the I/Q output FIFOs into the Y sample memories
module intpol2_sink_ctrl
  import intpol2_pkg::*;
#(
  parameter int ADDR_WIDTH = INTPOL2_ADDR_WIDTH,
  parameter int DATA_WIDTH = INTPOL2_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic                  Empty_i,
  input  logic [DATA_WIDTH-1:0] data_I_i,
  input  logic [DATA_WIDTH-1:0] data_Q_i,
  output logic                  Read_Enable_o,
  output logic                  Write_Enable_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_I_o,
  output logic [DATA_WIDTH-1:0] data_Q_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] count_o
);

  sink_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  re;
  logic                  start_accept;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic                  pending;

  // State, programmed length and issued-read count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Next state, read strobe and start acceptance
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_cnt_d     = rd_cnt_q;
    re           = 1'b0;
    start_accept = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_accept = 1'b1;
          len_d        = len_i;
          rd_cnt_d     = '0;
          state_d      = (len_i == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        re = !Empty_i && !stall_i && (rd_cnt_q != len_q);
        if (re) begin
          rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
        end
        if (rd_cnt_d == len_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The last write is retiring this cycle, so done lands right after it
        if ((wr_next == len_q) && !pending) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  intpol2_sink_wr_stage #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wr_stage (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (start_accept),
    .re_i     (re),
    .data_I_i (data_I_i),
    .data_Q_i (data_Q_i),
    .we_o     (Write_Enable_o),
    .addr_o   (addr_o),
    .data_I_o (data_I_o),
    .data_Q_o (data_Q_o),
    .wr_cnt_o (wr_cnt),
    .wr_next_o(wr_next),
    .pending_o(pending)
  );

  assign Read_Enable_o = re;
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done_o        = (state_q == ST_DONE);
  assign count_o       = wr_cnt;

endmodule

// File: tb/tb_intpol2_sink_ctrl.sv
// tb/tb_intpol2_sink_ctrl.sv - randomized bench with a transaction-level capture model
module tb_intpol2_sink_ctrl;

  localparam int AW = 20;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [AW-1:0] len_i = '0;
  logic          Empty_i = 1'b1;
  logic [DW-1:0] data_I_i = '0;
  logic [DW-1:0] data_Q_i = '0;
  logic          Read_Enable_o;
  logic          Write_Enable_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_I_o;
  logic [DW-1:0] data_Q_o;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] count_o;

  always #5 clk = ~clk;

  intpol2_sink_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .stall_i(stall_i), .len_i(len_i),
    .Empty_i(Empty_i), .data_I_i(data_I_i), .data_Q_i(data_Q_i),
    .Read_Enable_o(Read_Enable_o), .Write_Enable_o(Write_Enable_o), .addr_o(addr_o),
    .data_I_o(data_I_o), .data_Q_o(data_Q_o), .busy_o(busy_o), .done_o(done_o),
    .count_o(count_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus knobs
  bit start_v = 0, stall_v = 0, force_empty = 0, bursty = 0, rand_mode = 0;
  int len_v = 0;

  // FIFO contents as seen by the sink
  logic [DW-1:0] fq_i[$], fq_q[$];

  // capture model: one run = len pairs, each read written 2 cycles later
  bit m_active = 0, m_done_cyc = 0;
  int m_len = 0, m_reads = 0, m_writes = 0;
  int wq_due[$], wq_addr[$];
  logic [DW-1:0] wq_i[$], wq_q[$];
  logic [DW-1:0] last_i = '0, last_q = '0;
  bit rd_pending = 0;
  logic [DW-1:0] rd_i, rd_q;

  // observations of the DUT for literal checks
  bit obs_done;
  int obs_count;
  int log_addr[$], log_di[$], log_dq[$];
  int first_re_cyc, first_we_cyc, last_we_cyc, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_di.delete(); log_dq.delete();
    first_re_cyc = -1; first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1;
  endtask

  task automatic model_reset();
    m_active = 0; m_done_cyc = 0; m_len = 0; m_reads = 0; m_writes = 0;
    wq_due.delete(); wq_addr.delete(); wq_i.delete(); wq_q.delete();
    last_i = '0; last_q = '0; rd_pending = 0;
  endtask

  task automatic cycle();
    bit exp_re, exp_we, next_done;
    @(negedge clk);
    cyc++;
    start_i = start_v;
    stall_i = stall_v;
    len_i   = AW'(len_v);
    if (bursty) force_empty = ((cyc / 3) % 2) == 1;
    Empty_i = force_empty || (fq_i.size() == 0);
    if (rd_pending) begin
      data_I_i = rd_i; data_Q_i = rd_q;
    end else begin
      data_I_i = DW'($urandom); data_Q_i = DW'($urandom);
    end
    rd_pending = 0;
    #1;
    exp_re = m_active && !Empty_i && !stall_i && (m_reads < m_len);
    exp_we = (wq_due.size() > 0) && (wq_due[0] == cyc);
    chk("read_enable", Read_Enable_o, exp_re);
    chk("write_enable", Write_Enable_o, exp_we);
    chk("busy", busy_o, m_active);
    chk("done", done_o, m_done_cyc);
    chk("count", count_o, m_writes);
    if (exp_we) begin
      chk("addr", addr_o, wq_addr[0]);
      chk("data_I", data_I_o, wq_i[0]);
      chk("data_Q", data_Q_o, wq_q[0]);
    end else begin
      chk("data_I_hold", data_I_o, last_i);
      chk("data_Q_hold", data_Q_o, last_q);
    end
    obs_done = done_o;
    obs_count = int'(count_o);
    if (Read_Enable_o && first_re_cyc < 0) first_re_cyc = cyc;
    if (Write_Enable_o) begin
      log_addr.push_back(int'(addr_o));
      log_di.push_back(int'(data_I_o));
      log_dq.push_back(int'(data_Q_o));
      last_we_cyc = cyc;
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
    if (done_o) done_cyc = cyc;
    next_done = 0;
    if (exp_we) begin
      last_i = wq_i.pop_front(); last_q = wq_q.pop_front();
      void'(wq_due.pop_front()); void'(wq_addr.pop_front());
      m_writes++;
    end
    if (exp_re) begin
      rd_i = fq_i.pop_front(); rd_q = fq_q.pop_front(); rd_pending = 1;
      wq_due.push_back(cyc + 2); wq_addr.push_back(m_reads);
      wq_i.push_back(rd_i); wq_q.push_back(rd_q);
      m_reads++;
    end
    if (m_active) begin
      if (m_writes == m_len) begin
        m_active = 0; next_done = 1;
      end
    end else if (start_i) begin
      m_len = len_v; m_reads = 0; m_writes = 0;
      if (len_v == 0) next_done = 1;
      else m_active = 1;
    end
    m_done_cyc = next_done;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; start_v = 0; start_i = 1'b0;
    #1;
    chk("rst_read_enable", Read_Enable_o, 0);
    chk("rst_write_enable", Write_Enable_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data_I", data_I_o, 0);
    chk("rst_data_Q", data_Q_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_o, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fq_i.push_back(DW'($urandom)); fq_q.push_back(DW'($urandom));
    end
  endtask

  task automatic pulse_start(input int len);
    start_v = 1; len_v = len;
    cycle();
    start_v = 0;
  endtask

  task automatic run_to_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (rand_mode) begin
        stall_v = ($urandom_range(0, 3) == 0);
        force_empty = ($urandom_range(0, 2) == 0);
        start_v = m_active && ($urandom_range(0, 9) == 0);
        len_v = $urandom_range(0, 40);
      end
      cycle();
      if (obs_done) begin seen = 1; break; end
    end
    start_v = 0;
    chk({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    int sz, start_cyc;
    bit ok, pulsed, reached;
    clear_logs();
    do_reset();
    cycle();

    // continuous drain of 10 prefilled pairs
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      fq_i.push_back(DW'(12'h001 + k)); fq_q.push_back(DW'(12'h801 + k));
    end
    pulse_start(10);
    run_to_done(100, "drain");
    chk("drain_nwrites", log_addr.size(), 10);
    ok = (log_addr.size() == 10);
    for (int k = 0; k < log_addr.size(); k++)
      if (log_addr[k] != k || log_di[k] != 1 + k || log_dq[k] != 'h801 + k) ok = 0;
    chk("drain_addr_data", ok, 1);
    chk("drain_first_we_latency", first_we_cyc - first_re_cyc, 2);
    chk("drain_done_after_last_we", done_cyc - last_we_cyc, 1);
    chk("drain_count", obs_count, 10);
    cycle();

    // bursty source
    clear_logs(); fill(20); bursty = 1;
    pulse_start(16);
    run_to_done(200, "bursty");
    bursty = 0; force_empty = 0;
    chk("bursty_nwrites", log_addr.size(), 16);
    ok = 1;
    for (int k = 0; k < log_addr.size(); k++) if (log_addr[k] != k) ok = 0;
    chk("bursty_contiguous", ok, 1);
    cycle();

    // long stall after 5 reads
    clear_logs(); fill(20);
    pulse_start(12);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle();
      if (m_reads >= 5) reached = 1;
    end
    chk("stall_reached_5_reads", reached, 1);
    stall_v = 1;
    sz = log_addr.size();
    for (int i = 0; i < 1000; i++) cycle();
    chk("stall_inflight_le2", (log_addr.size() - sz) <= 2, 1);
    chk("stall_count_frozen", obs_count, 5);
    stall_v = 0;
    run_to_done(100, "stall");
    chk("stall_final_count", obs_count, 12);
    chk("stall_nwrites", log_addr.size(), 12);
    cycle();

    // zero length
    clear_logs();
    start_cyc = cyc + 1;
    pulse_start(0);
    run_to_done(10, "zero");
    chk("zero_done_latency", done_cyc - start_cyc, 1);
    chk("zero_nwrites", log_addr.size(), 0);
    chk("zero_no_read", first_re_cyc, -1);
    cycle();

    // ignored start during RUN, then restart in the done cycle
    clear_logs(); fill(12);
    pulse_start(6);
    pulsed = 0; reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      start_v = 0;
      if (!pulsed && m_reads == 2) begin start_v = 1; len_v = 9; pulsed = 1; end
      if (m_done_cyc) reached = 1;
      else cycle();
    end
    chk("restart_reached_done", reached, 1);
    pulse_start(4);
    chk("restart_first_run_writes", log_addr.size(), 6);
    sz = log_addr.size();
    run_to_done(100, "restart");
    chk("restart_total_writes", log_addr.size(), 10);
    ok = (log_addr.size() == 10);
    for (int k = 0; k < 4 && ok; k++) if (log_addr[sz + k] != k) ok = 0;
    chk("restart_addrs", ok, 1);
    cycle();

    // reset in the middle of a 20-pair run
    clear_logs(); fill(25);
    pulse_start(20);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      cycle();
      if (obs_count == 7) reached = 1;
    end
    chk("rst_reached_count7", reached, 1);
    do_reset();
    clear_logs();
    pulse_start(3);
    run_to_done(50, "post_reset");
    chk("post_reset_nwrites", log_addr.size(), 3);
    ok = (log_addr.size() == 3);
    for (int k = 0; k < log_addr.size(); k++) if (log_addr[k] != k) ok = 0;
    chk("post_reset_addrs", ok, 1);
    cycle();

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      clear_logs(); fill(40);
      pulse_start($urandom_range(0, 30));
      rand_mode = 1;
      run_to_done(600, "random");
      rand_mode = 0; stall_v = 0; force_empty = 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
